led_step_controller: RTL and testbench
======================================

Name: led_step_controller

Overview:
- Sequences the 4-state LED pattern FSM by generating its advance input as a clean single-cycle `step_o` pulse.
- Replaces the raw button drive, which advances the FSM on every clock while held.
- Three modes: MANUAL (one step per debounced press), AUTO (periodic stepping) and PAUSED (AUTO frozen, single-step allowed).
- Sits between the board buttons and the LED FSM; `step_o` connects to the FSM's `btnD` input.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- AUTO_PERIOD, 50000000, clock cycles between automatic steps in AUTO (0.5 s at 100 MHz).
- CNT_W, 8, width of the step counter output.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- btnD  in  1  raw step button, active high
- btnC  in  1  raw mode-toggle button (MANUAL<->AUTO)
- btnU  in  1  raw pause/resume button
- step_o  out  1  one-cycle advance pulse to the LED FSM
- mode_o  out  2  current mode: 00 MANUAL, 01 AUTO, 10 PAUSED
- step_count_o  out  CNT_W  total steps issued, modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, async): mode_o=00, step_o=0, step_count_o=0; all debounce state, synchronizers and the period counter cleared.
- Reset mid-operation: everything returns to reset values immediately; no step_o is issued in the reset-release cycle.
- Each button path:
  - 2-FF synchronizer, then debounce counter; the debounced level updates only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level.
  - press = one-cycle pulse on the debounced rising edge; releases generate nothing.
- Latency: step_o for a MANUAL press is high exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge that samples btnD high.
- Glitches shorter than DEBOUNCE_CYCLES are rejected.
- A button held through reset release is treated as a new press after debounce.
- Mode FSM transitions:
  - MANUAL: mode press -> AUTO; pause press ignored.
  - AUTO: mode press -> MANUAL; pause press -> PAUSED.
  - PAUSED: pause press -> AUTO; mode press -> MANUAL.
- Same-cycle press priority: mode > pause > step. Lower-priority presses in that cycle are dropped. No step_o is issued in a cycle where the mode changes.
- Period counter:
  - Counts only in AUTO and is cleared on entry to AUTO from MANUAL.
  - On reaching AUTO_PERIOD-1, it issues an auto step and wraps to 0.
  - First auto step occurs AUTO_PERIOD cycles after the mode-change cycle.
  - Held (not cleared) in PAUSED; resuming continues from the held value.
- step_o sources:
  - MANUAL: step press.
  - AUTO: auto tick, or a step press, which also clears the period counter. A tick coinciding with a step press yields one step_o, not two.
  - PAUSED: step press only (single-step).
- step_o is registered and never high two consecutive cycles from a single event.
- step_count_o increments by 1 on every step_o cycle, wraps 2^CNT_W-1 -> 0, and is visible the cycle after step_o.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package lab_ctrl_pkg: mode encodings MODE_MANUAL=2'b00, MODE_AUTO=2'b01, MODE_PAUSED=2'b10.
- Sub-module button_debounce (synchronizer + debounce counter + press-pulse generator, parameter DEBOUNCE_CYCLES), instantiated three times.
- Mode FSM, period counter and step counter live in led_step_controller.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_PERIOD=10, CNT_W=8):
- btnD high for 20 cycles in MANUAL -> exactly one step_o, 7 cycles after first sampled high; step_count_o 0->1.
- btnD high 3 cycles then low -> no step_o, step_count_o stays 0.
- btnC press, no further input for 35 cycles -> mode_o=01; step_o at 10, 20, 30 cycles after the mode-change cycle; step_count_o=3.
- In AUTO, btnU press at period count 6 -> mode_o=10, no auto steps for 50 cycles.
  - Then btnD press -> single step_o.
  - Then btnU press -> mode_o=01, next auto step 4 cycles later.
- In AUTO, btnC and btnD debounced presses land in the same cycle -> mode_o=00, no step_o in that cycle.
- 256 manual presses -> step_count_o wraps to 0; then rst_n low mid-AUTO -> mode_o=00, step_o=0, step_count_o=0 immediately, no step on release.

Source files
------------

// File: rtl/lab_ctrl_pkg.sv
// rtl/lab_ctrl_pkg.sv - shared mode encodings for the LED step controller
package lab_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_PAUSED = 2'b10
    } mode_e;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchronizer, debounce counter and press pulse
//   clk, rst_n : clock, async active-low reset
//   btn_i      : raw asynchronous button level
//   press_o    : registered one-cycle pulse on the debounced rising edge
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any return to agreement restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_step_controller.sv
// rtl/led_step_controller.sv - mode FSM, auto period timer and step pulse for the LED FSM
//   clk, rst_n   : clock, async active-low reset
//   btnD         : raw step button
//   btnC         : raw mode toggle button (MANUAL<->AUTO)
//   btnU         : raw pause/resume button
//   step_o       : registered one-cycle advance pulse
//   mode_o       : current mode (00 MANUAL, 01 AUTO, 10 PAUSED)
//   step_count_o : steps issued, modulo 2^CNT_W
module led_step_controller
    import lab_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btnD,
    input  logic             btnC,
    input  logic             btnU,
    output logic             step_o,
    output logic [1:0]       mode_o,
    output logic [CNT_W-1:0] step_count_o
);

    localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(AUTO_PERIOD - 1);

    logic             step_press, mode_press, pause_press;
    mode_e            mode_q, mode_d;
    logic [PW-1:0]    period_q, period_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] count_q;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btnD),
        .press_o(step_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btnC),
        .press_o(mode_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btnU),
        .press_o(pause_press)
    );

    // Priority is mode > pause > step within each state. The period counter
    // only advances on cycles that stay in AUTO, so it is frozen both on the
    // pausing cycle and on the resuming cycle.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        step_d   = 1'b0;
        case (mode_q)
            MODE_MANUAL: begin
                if (mode_press) begin
                    mode_d   = MODE_AUTO;
                    period_d = '0;
                end else if (step_press) begin
                    step_d = 1'b1;
                end
            end
            MODE_AUTO: begin
                if (mode_press) begin
                    mode_d = MODE_MANUAL;
                end else if (pause_press) begin
                    mode_d = MODE_PAUSED;
                end else if (step_press || period_q == PERIOD_LAST) begin
                    // A manual step restarts the period; a coincident tick
                    // folds into the same single pulse.
                    step_d   = 1'b1;
                    period_d = '0;
                end else begin
                    period_d = period_q + 1'b1;
                end
            end
            MODE_PAUSED: begin
                if (mode_press) begin
                    mode_d = MODE_MANUAL;
                end else if (pause_press) begin
                    mode_d = MODE_AUTO;
                end else if (step_press) begin
                    step_d = 1'b1;
                end
            end
            default: begin
                mode_d = MODE_MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_MANUAL;
            period_q <= '0;
            step_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            step_q   <= step_d;
            if (step_q) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign step_o       = step_q;
    assign mode_o       = mode_q;
    assign step_count_o = count_q;

endmodule

// File: tb/tb_led_step_controller.sv
// tb/tb_led_step_controller.sv - directed bench for led_step_controller
module tb_led_step_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnD = 1'b0;
    logic       btnC = 1'b0;
    logic       btnU = 1'b0;
    logic       step_o;
    logic [1:0] mode_o;
    logic [7:0] step_count_o;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int steps[$];

    led_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (10),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btnD        (btnD),
        .btnC        (btnC),
        .btnU        (btnU),
        .step_o      (step_o),
        .mode_o      (mode_o),
        .step_count_o(step_count_o)
    );

    always #5 clk = ~clk;

    // cyc holds the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_o) steps.push_back(cyc);
    end

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns just after edge number n (at +1 time unit).
    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise the buttons in mask {U,C,D} so that edge 'first' is the first one
    // sampling them high, and keep them high for 'hold' sampling edges.
    task automatic press_at(input int first, input logic [2:0] mask, input int hold);
        wait_edge(first - 1);
        {btnU, btnC, btnD} = mask;
        wait_edge(first + hold - 1);
        {btnU, btnC, btnD} = 3'b000;
    endtask

    task automatic check_steps(input string tag, input int n, input int e0, input int e1, input int e2);
        int e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        check({tag, "_nsteps"}, steps.size(), n);
        for (int i = 0; i < n && i < steps.size(); i++) begin
            check({tag, "_step_cycle"}, steps[i], e[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int m;
        int t;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mode", mode_o, 0);
        check("rst_step", step_o, 0);
        check("rst_count", step_count_o, 0);
        wait_edge(5);
        rst_n = 1'b1;

        // 3-cycle glitch is rejected
        steps.delete();
        press_at(10, 3'b001, 3);
        wait_edge(25);
        check_steps("glitch", 0, 0, 0, 0);
        check("glitch_count", step_count_o, 0);

        // Held button: one step, 7 cycles after first sampled high
        press_at(30, 3'b001, 20);
        wait_edge(55);
        check_steps("manual", 1, 37, 0, 0);
        check("manual_count", step_count_o, 1);
        check("manual_mode", mode_o, 0);

        // Mode press: AUTO at edge 67, ticks at +10, +20, +30
        steps.delete();
        press_at(60, 3'b010, 6);
        m = 67;
        wait_edge(m + 35);
        check("auto_mode", mode_o, 1);
        check_steps("auto", 3, m + 10, m + 20, m + 30);
        check("auto_count", step_count_o, 4);

        // Pause lands at edge 114 with period count 6; only the 107 tick precedes it
        steps.delete();
        press_at(m + 40, 3'b100, 6);
        wait_edge(164);
        check("pause_mode", mode_o, 2);
        check_steps("pause", 1, 107, 0, 0);
        check("pause_count", step_count_o, 5);

        // Single step while paused
        steps.delete();
        press_at(170, 3'b001, 6);
        wait_edge(185);
        check_steps("single", 1, 177, 0, 0);
        check("single_mode", mode_o, 2);
        check("single_count", step_count_o, 6);

        // Resume at edge 197 continues from 6: tick 4 cycles later
        steps.delete();
        press_at(190, 3'b100, 6);
        wait_edge(205);
        check("resume_mode", mode_o, 1);
        check_steps("resume", 1, 201, 0, 0);
        check("resume_count", step_count_o, 7);

        // Mode and step presses land together at edge 217: mode wins, no step
        steps.delete();
        press_at(210, 3'b011, 6);
        wait_edge(235);
        check("both_mode", mode_o, 0);
        check_steps("both", 1, 211, 0, 0);
        check("both_count", step_count_o, 8);

        // Counter wrap after 256 manual presses, starting from a fresh reset
        rst_n = 1'b0;
        wait_edge(240);
        rst_n = 1'b1;
        steps.delete();
        for (int i = 0; i < 255; i++) begin
            press_at(cyc + 2, 3'b001, 6);
            wait_edge(cyc + 6);
        end
        wait_edge(cyc + 10);
        check("wrap_nsteps", steps.size(), 255);
        check("wrap_count_255", step_count_o, 255);
        press_at(cyc + 2, 3'b001, 6);
        wait_edge(cyc + 10);
        check("wrap_count_0", step_count_o, 0);

        // Reset asserted while an auto step pulse is high
        t = cyc + 2;
        press_at(t, 3'b010, 6);
        m = t + 7;
        wait_edge(m + 15);
        check("pre_rst_mode", mode_o, 1);
        check("pre_rst_count", step_count_o, 1);
        wait_edge(m + 20);
        check("pre_rst_step", step_o, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mode", mode_o, 0);
        check("async_rst_step", step_o, 0);
        check("async_rst_count", step_count_o, 0);
        wait_edge(m + 23);
        steps.delete();
        rst_n = 1'b1;
        wait_edge(m + 45);
        check_steps("post_rst", 0, 0, 0, 0);
        check("post_rst_mode", mode_o, 0);
        check("post_rst_count", step_count_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
